keyboard_fifo_wb: RTL and testbench

//  BK-0011M keyboard register block (177660 status / 177662 data) with a parametrised key FIFO and optional typematic repeat.

---
 rtl/keyboard_fifo_wb.sv | 205 ++++++++++++++++++++
 tb/tb_keyboard_fifo_wb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/keyboard_fifo_wb.sv
// BK-0011M keyboard registers (177660 status / 177662 data) with a key FIFO and vectored IRQs.
// Optional typematic repeat is enabled by defining KBD_AUTOREPEAT_EN.
module keyboard_fifo_wb #(
  parameter int DEPTH      = 8,
  parameter int REP_DELAY  = 12000000,
  parameter int REP_PERIOD = 2400000
) (
  input  logic                     clk_bus,
  input  logic                     bus_reset,
  input  logic [15:0]              bus_din,
  output logic [15:0]              bus_dout,
  input  logic [15:0]              bus_addr,
  input  logic                     bus_sync,
  input  logic                     bus_we,
  input  logic                     bus_stb,
  output logic                     bus_ack,
  output logic                     virq_req60,
  input  logic                     virq_ack60,
  output logic                     virq_req274,
  input  logic                     virq_ack274,
  input  logic                     key_strobe,
  input  logic [6:0]               key_code,
  input  logic                     key_vec274,
  input  logic                     key_held,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [15:0] A660 = 16'o177660;
  localparam logic [15:0] A662 = 16'o177662;

  logic sel660, sel662, stb_qual, stb_rise;
  logic rd660, wr660, rd662, mask_wr1;
  logic stb_q, stb_d;
  logic [15:0] dout_q, dout_d;
  logic [6:0] last_q, last_d;
  logic ovf_q, ovf_d, mask_q, mask_d;
  logic sig_q, sig_d, req60_q, req60_d, req274_q, req274_d;
  logic ack60_q, ack60_d, ack274_q, ack274_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [7:0] fifo_mem [DEPTH];
  logic [7:0] head, push_data, rep_entry;
  logic empty, full, pop, push_req, push_key, push_rep, push, ovf_set, raise;
  logic rep_fire;
  logic unused_bits;

  assign unused_bits = ^{bus_din[15:7], bus_din[5:0], bus_addr[0]};

  assign sel660   = bus_sync && (bus_addr[15:1] == A660[15:1]);
  assign sel662   = bus_sync && (bus_addr[15:1] == A662[15:1]) && !bus_we;
  assign stb_qual = bus_stb && (sel660 || sel662);
  assign stb_rise = stb_qual && !stb_q;
  assign bus_ack  = stb_qual && stb_q;
  assign bus_dout = (sel660 || sel662) ? dout_q : 16'h0000;

  assign rd660    = stb_rise && sel660 && !bus_we;
  assign wr660    = stb_rise && sel660 && bus_we;
  assign rd662    = stb_rise && sel662;
  assign mask_wr1 = wr660 && bus_din[6];

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign head     = fifo_mem[rd_ptr_q];
  assign pop      = rd662 && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_req = key_strobe && (key_code != 7'd0);
  assign push_key = push_req && (!full || pop);
  assign push_rep = rep_fire && !push_req && (!full || pop);
  assign push     = push_key || push_rep;
  assign push_data = push_req ? {key_vec274, key_code} : rep_entry;
  assign ovf_set  = push_req && full && !pop;
  assign raise    = !empty && !mask_q && !sig_q && !pop && !mask_wr1;

  assign virq_req60  = req60_q;
  assign virq_req274 = req274_q;
  assign fifo_level  = count_q;

`ifdef KBD_AUTOREPEAT_EN
  logic [31:0] rep_cnt_q, rep_cnt_d;
  logic rep_act_q, rep_act_d;
  logic [7:0] rep_entry_q, rep_entry_d;

  // The counter holds the cycles left including the current one, so 1 means fire now.
  assign rep_fire  = rep_act_q && key_held && (rep_cnt_q == 32'd1);
  assign rep_entry = rep_entry_q;

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_act_d   = rep_act_q;
    rep_entry_d = rep_entry_q;
    if (push_req) begin
      rep_act_d = push_key;
      if (push_key) begin
        rep_cnt_d   = 32'(REP_DELAY);
        rep_entry_d = {key_vec274, key_code};
      end
    end else if (rep_act_q) begin
      if (!key_held) rep_act_d = 1'b0;
      else if (rep_fire) rep_cnt_d = 32'(REP_PERIOD);
      else rep_cnt_d = rep_cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_entry_q <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_entry_q <= rep_entry_d;
    end
  end
`else
  logic unused_held;
  assign unused_held = key_held;
  assign rep_fire    = 1'b0;
  assign rep_entry   = 8'h00;
`endif

  always_comb begin
    stb_d    = stb_qual;
    dout_d   = dout_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    mask_d   = mask_q;
    sig_d    = sig_q;
    req60_d  = req60_q;
    req274_d = req274_q;
    ack60_d  = virq_ack60;
    ack274_d = virq_ack274;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    if (!push && pop) count_d = count_q - 1'b1;

    if (rd660) begin
      dout_d = {1'b0, ovf_q, 6'b0, !empty, mask_q, 6'b0};
      ovf_d  = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (wr660) mask_d = bus_din[6];

    if (rd662) begin
      if (empty) begin
        dout_d = {9'b0, last_q};
      end else begin
        dout_d = {9'b0, head[6:0]};
        last_d = head[6:0];
      end
    end

    if (pop) sig_d = 1'b0;
    if (raise) begin
      sig_d = 1'b1;
      if (head[7]) req274_d = 1'b1;
      else req60_d = 1'b1;
    end else begin
      if ((virq_ack60 && !ack60_q) || rd662 || mask_wr1) req60_d = 1'b0;
      if ((virq_ack274 && !ack274_q) || rd662 || mask_wr1) req274_d = 1'b0;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      stb_q    <= 1'b0;
      dout_q   <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      mask_q   <= 1'b1;
      sig_q    <= 1'b0;
      req60_q  <= 1'b0;
      req274_q <= 1'b0;
      ack60_q  <= 1'b0;
      ack274_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      stb_q    <= stb_d;
      dout_q   <= dout_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      mask_q   <= mask_d;
      sig_q    <= sig_d;
      req60_q  <= req60_d;
      req274_q <= req274_d;
      ack60_q  <= ack60_d;
      ack274_q <= ack274_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (push && !bus_reset) fifo_mem[wr_ptr_q] <= push_data;
  end
endmodule

// File: tb/tb_keyboard_fifo_wb.sv
// Directed bench for keyboard_fifo_wb: register decode, FIFO order/overflow, IRQs, reset, repeat.
// Expected repeat behaviour follows KBD_AUTOREPEAT_EN when it is defined for the build.
module tb_keyboard_fifo_wb;
  logic        clk = 1'b0;
  logic        bus_reset = 1'b1;
  logic [15:0] bus_din = '0;
  logic [15:0] bus_dout;
  logic [15:0] bus_addr = '0;
  logic        bus_sync = 1'b0;
  logic        bus_we = 1'b0;
  logic        bus_stb = 1'b0;
  logic        bus_ack;
  logic        virq_req60;
  logic        virq_ack60 = 1'b0;
  logic        virq_req274;
  logic        virq_ack274 = 1'b0;
  logic        key_strobe = 1'b0;
  logic [6:0]  key_code = '0;
  logic        key_vec274 = 1'b0;
  logic        key_held = 1'b0;
  logic [3:0]  fifo_level;

  int tests = 0;
  int fails = 0;
  logic [15:0] rd;

  localparam logic [15:0] R660 = 16'o177660;
  localparam logic [15:0] R662 = 16'o177662;

  always #5 clk = ~clk;

  keyboard_fifo_wb #(.DEPTH(8), .REP_DELAY(10), .REP_PERIOD(4)) dut (
    .clk_bus(clk), .bus_reset(bus_reset), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_addr(bus_addr), .bus_sync(bus_sync), .bus_we(bus_we), .bus_stb(bus_stb),
    .bus_ack(bus_ack), .virq_req60(virq_req60), .virq_ack60(virq_ack60),
    .virq_req274(virq_req274), .virq_ack274(virq_ack274), .key_strobe(key_strobe),
    .key_code(key_code), .key_vec274(key_vec274), .key_held(key_held),
    .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read cycle; kc != 0 also strobes a key on the same cycle as the strobe's rising edge.
  task automatic bus_rd(input logic [15:0] a, input logic [6:0] kc, output logic [15:0] d);
    int n;
    @(negedge clk);
    bus_sync = 1'b1; bus_addr = a; bus_we = 1'b0; bus_stb = 1'b1;
    if (kc != 7'd0) begin key_strobe = 1'b1; key_code = kc; key_vec274 = 1'b0; end
    @(negedge clk);
    key_strobe = 1'b0;
    n = 1;
    while (!bus_ack && n < 8) begin @(negedge clk); n++; end
    check("rd_ack", {31'b0, bus_ack}, 32'd1);
    check("rd_ack_lat", n, 1);
    d = bus_dout;
    $display("[TB] read  %o -> %o level=%0d", a, d, fifo_level);
    bus_stb = 1'b0; bus_sync = 1'b0; bus_addr = '0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] v);
    int n;
    @(negedge clk);
    bus_sync = 1'b1; bus_addr = a; bus_we = 1'b1; bus_din = v; bus_stb = 1'b1;
    @(negedge clk);
    n = 1;
    while (!bus_ack && n < 8) begin @(negedge clk); n++; end
    check("wr_ack", {31'b0, bus_ack}, 32'd1);
    $display("[TB] write %o <- %o", a, v);
    bus_stb = 1'b0; bus_sync = 1'b0; bus_we = 1'b0; bus_addr = '0;
  endtask

  task automatic push(input logic [6:0] kc, input logic v);
    @(negedge clk);
    key_strobe = 1'b1; key_code = kc; key_vec274 = v;
    @(negedge clk);
    key_strobe = 1'b0;
    $display("[TB] push  %o vec274=%0d level=%0d", kc, v, fifo_level);
  endtask

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_level", fifo_level, 0);
    check("rst_req60", virq_req60, 0);
    check("rst_req274", virq_req274, 0);
    check("rst_ack", bus_ack, 0);
    bus_reset = 1'b0;
    bus_rd(R660, 0, rd);
    check("rst_status", rd, 16'o000100);

    // 2: masked queueing, empty read returns last code
    push(7'o101, 0);
    push(7'o102, 0);
    check("t2_level", fifo_level, 2);
    bus_rd(R660, 0, rd);
    check("t2_status", rd, 16'o000300);
    bus_rd(R662, 0, rd);
    check("t2_rd1", rd, 16'o000101);
    bus_rd(R662, 0, rd);
    check("t2_rd2", rd, 16'o000102);
    check("t2_noreq", {virq_req60, virq_req274}, 0);
    bus_rd(R662, 0, rd);
    check("t2_rd3", rd, 16'o000102);
    check("t2_level0", fifo_level, 0);

    // 3: interrupts
    bus_wr(R660, 16'o000000);
    push(7'o101, 0);
    repeat (2) @(negedge clk);
    check("t3_req60", virq_req60, 1);
    check("t3_req274_off", virq_req274, 0);
    @(negedge clk); virq_ack60 = 1'b1;
    @(negedge clk); virq_ack60 = 1'b0;
    check("t3_req60_acked", virq_req60, 0);
    @(negedge clk);
    check("t3_no_reraise", virq_req60, 0);
    bus_rd(R662, 0, rd);
    check("t3_rdA", rd, 16'o000101);
    push(7'o061, 1);
    repeat (2) @(negedge clk);
    check("t3_req274", virq_req274, 1);
    check("t3_req60_off", virq_req60, 0);
    bus_rd(R662, 0, rd);
    check("t3_rd274", rd, 16'o000061);
    check("t3_req274_clr", virq_req274, 0);

    // 4: overflow
    for (int i = 1; i <= 9; i++) push(7'(i), 0);
    check("t4_level", fifo_level, 8);
    bus_rd(R660, 0, rd);
    check("t4_status", rd, 16'o040200);
    for (int i = 1; i <= 8; i++) begin
      bus_rd(R662, 0, rd);
      check("t4_order", rd, 32'(i));
    end
    check("t4_level0", fifo_level, 0);
    bus_rd(R660, 0, rd);
    check("t4_ovf_clr", rd, 16'o000000);

    // 5: simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push(7'(8'h11 + i), 0);
    check("t5_full", fifo_level, 8);
    bus_rd(R662, 7'h19, rd);
    check("t5_pop", rd, 16'h0011);
    check("t5_level", fifo_level, 8);
    bus_rd(R660, 0, rd);
    check("t5_status", rd, 16'o000200);
    for (int i = 0; i < 8; i++) begin
      bus_rd(R662, 0, rd);
      check("t5_order", rd, 32'(8'h12 + i));
    end
    check("t5_level0", fifo_level, 0);

    // reset in the middle of a data read
    push(7'h21, 0);
    push(7'h22, 0);
    @(negedge clk);
    bus_sync = 1'b1; bus_addr = R662; bus_we = 1'b0; bus_stb = 1'b1; bus_reset = 1'b1;
    @(negedge clk);
    check("mrst_ack", bus_ack, 0);
    check("mrst_level", fifo_level, 0);
    bus_reset = 1'b0; bus_stb = 1'b0; bus_sync = 1'b0; bus_addr = '0;
    bus_rd(R660, 0, rd);
    check("mrst_status", rd, 16'o000100);
    bus_rd(R662, 0, rd);
    check("mrst_hold", rd, 16'o000000);

    // 6: typematic repeat (key held 30 cycles after the push)
    @(negedge clk);
    key_strobe = 1'b1; key_code = 7'h58; key_vec274 = 1'b0; key_held = 1'b1;
    @(negedge clk);
    key_strobe = 1'b0;
    repeat (29) @(negedge clk);
    key_held = 1'b0;
    @(negedge clk);
`ifdef KBD_AUTOREPEAT_EN
    check("t6_repeats", fifo_level, 6);
`else
    check("t6_no_repeat", fifo_level, 1);
`endif
    bus_rd(R662, 0, rd);
    check("t6_code", rd, 16'h0058);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
